// File: rtl/audio_gain_join_if.sv
// audio_gain_join_if
//   Bundles the sample-stream and frame-output signals of audio_gain_join.
//   master : upstream side (drives strobes, samples and volume, observes frames)
//   slave  : the gain/join block itself
//   Signals:
//     in_valid  [CHANNELS]             per-channel one-cycle "sample done" strobe
//     in_data   [CHANNELS*DATA_WIDTH]  samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//     volume    [DATA_WIDTH]           signed fixed-point gain
//     out_data  [CHANNELS*DATA_WIDTH]  gained frame, same packing as in_data
//     out_valid                        one-cycle pulse when out_data updates
//     busy                             high while a frame is being multiplied
//     overrun   [CHANNELS]             sticky per-channel dropped-sample flags
interface audio_gain_join_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 2
);
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic signed [DATA_WIDTH-1:0]   volume;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data;
  logic                           out_valid;
  logic                           busy;
  logic [CHANNELS-1:0]            overrun;

  modport master (
    output in_valid, in_data, volume,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  in_valid, in_data, volume,
    output out_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/audio_gain_join.sv
// audio_gain_join
//   Joins one sample per channel from independently completing filters, then
//   applies a signed fixed-point volume to every channel through one shared
//   multiplier (one channel per cycle), saturates, and publishes the frame
//   with a single-cycle out_valid pulse.
//   Ports:
//     clock  rising-edge system clock
//     reset  asynchronous active-high reset, clears all state
//     bus    audio_gain_join_if.slave (in_valid/in_data/volume in,
//            out_data/out_valid/busy/overrun out)
module audio_gain_join #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int FRAC_BITS  = 10
) (
  input logic             clock,
  input logic             reset,
  audio_gain_join_if.slave bus
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] SAT_HI = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, MULT} state_t;

  function automatic logic signed [PW-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
    if (v > SAT_HI) return SAT_HI[DATA_WIDTH-1:0];
    if (v < SAT_LO) return SAT_LO[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   cap_q  [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   cap_d  [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   work_q [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   work_d [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   res_q  [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   res_d  [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   vol_q, vol_d;
  logic [CHANNELS-1:0]            pend_q, pend_d;
  logic [CHANNELS-1:0]            ovr_q, ovr_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                           out_valid_q, out_valid_d;
  logic                           busy;
  logic                           join_now;
  logic                           last_mult;
  logic signed [PW-1:0]           prod;
  logic signed [DATA_WIDTH-1:0]   gained;

  assign join_now  = (state_q == IDLE) && (&pend_q);
  assign last_mult = (state_q == MULT) && (idx_q == LAST_IDX);

  // ---- FSM: state register ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (join_now)  state_d = MULT;
      MULT:    if (last_mult) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state_q != IDLE);
  end

  // ---- Capture, join and multiply datapath ----
  always_comb begin
    cap_d       = cap_q;
    work_d      = work_q;
    res_d       = res_q;
    vol_d       = vol_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    prod        = '0;
    gained      = '0;

    // The join moves captures into the work registers, freeing the capture
    // registers on that same edge so a strobe there is accepted, not dropped.
    if (join_now) begin
      work_d = cap_q;
      vol_d  = bus.volume;
      pend_d = '0;
      idx_d  = '0;
    end

    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.in_valid[c]) begin
        if (!pend_q[c] || join_now) begin
          cap_d[c]  = bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
          pend_d[c] = 1'b1;
        end else begin
          ovr_d[c] = 1'b1;
        end
      end
    end

    if (state_q == MULT) begin
      prod          = sext(work_q[idx_q]) * sext(vol_q);
      // >>> on a signed value floors toward minus infinity.
      gained        = saturate(prod >>> FRAC_BITS);
      res_d[idx_q]  = gained;
      idx_d         = idx_q + 1'b1;
      if (last_mult) begin
        for (int c = 0; c < CHANNELS; c++)
          out_data_d[c*DATA_WIDTH +: DATA_WIDTH] = res_q[c];
        // Last channel's result goes straight out; its res_q slot is not yet written.
        out_data_d[(CHANNELS-1)*DATA_WIDTH +: DATA_WIDTH] = gained;
        out_valid_d = 1'b1;
        idx_d       = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cap_q[c]  <= '0;
        work_q[c] <= '0;
        res_q[c]  <= '0;
      end
      vol_q       <= '0;
      pend_q      <= '0;
      ovr_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      work_q      <= work_d;
      res_q       <= res_d;
      vol_q       <= vol_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_audio_gain_join.sv
// tb_audio_gain_join
//   Directed bench for audio_gain_join with two 32-bit channels and 10
//   fractional volume bits. Expected values are worked out by hand.
module tb_audio_gain_join;

  localparam int DW = 32;
  localparam int CH = 2;
  localparam int FB = 10;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  audio_gain_join_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

  audio_gain_join #(.DATA_WIDTH(DW), .CHANNELS(CH), .FRAC_BITS(FB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle strobe on the channels in v; data packed {ch1, ch0}.
  task automatic drive(input logic [1:0] v, input logic signed [DW-1:0] d0,
                       input logic signed [DW-1:0] d1);
    bus.in_valid = v;
    bus.in_data  = {d1, d0};
    tick();
    bus.in_valid = '0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = i[1:0];
      bus.in_data  = {32'(i * 17), 32'(i * 3 + 1)};
      tick();
      vectors++;
      if ({bus.out_valid, bus.busy, bus.overrun, bus.out_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold: got valid=%b busy=%b ovr=%b data=%h required all 0",
                 bus.out_valid, bus.busy, bus.overrun, bus.out_data);
      end
    end
    bus.in_valid = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.out_valid, bus.busy, bus.overrun, bus.out_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_release: got valid=%b busy=%b ovr=%b data=%h required all 0",
                 bus.out_valid, bus.busy, bus.overrun, bus.out_data);
      end
    end
  endtask

  task automatic test_basic();
    int busy_cnt, pulse_cnt, pulse_at, busy_at_pulse;
    logic [2*DW-1:0] got, exp;
    busy_cnt = 0; pulse_cnt = 0; pulse_at = -1; busy_at_pulse = 1; got = '0;
    exp = {-32'sd1000, 32'sd1000};
    bus.volume = 32'sd1024;
    drive(2'b11, 32'sd1000, -32'sd1000);   // edge E0
    for (int k = 1; k <= 6; k++) begin
      tick();                              // edge E(k)
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) begin
        pulse_cnt++;
        pulse_at = k;
        got = bus.out_data;
        busy_at_pulse = bus.busy;
      end
    end
    vectors++;
    if (pulse_cnt != 1 || pulse_at != 3) begin
      miscompares++;
      $display("FAIL basic_pulse: got %0d pulses, last after E%0d; required 1 after E3",
               pulse_cnt, pulse_at);
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL basic_data: got %h required %h", got, exp);
    end
    // busy covers the MULT state only: cycles after E1 and E2.
    vectors++;
    if (busy_cnt != CH || busy_at_pulse != 0) begin
      miscompares++;
      $display("FAIL basic_busy: got %0d busy cycles (busy at pulse=%0d) required %0d (0)",
               busy_cnt, busy_at_pulse, CH);
    end
    vectors++;
    if (bus.out_data !== exp) begin
      miscompares++;
      $display("FAIL basic_hold: got %h required %h", bus.out_data, exp);
    end
  endtask

  task automatic test_staggered();
    bit seen;
    logic [2*DW-1:0] exp;
    exp = {-32'sd2, 32'sd500};
    bus.volume = 32'sd512;
    drive(2'b01, 32'sd1000, 32'sd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stagger_wait: got valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
      end
    end
    drive(2'b10, 32'sd0, -32'sd3);
    wait_valid(8, seen);
    vectors++;
    if (!seen || bus.out_data !== exp) begin
      miscompares++;
      $display("FAIL stagger_data: got seen=%0d data=%h required 1 %h", seen, bus.out_data, exp);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stagger_single: got out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    bit seen;
    logic [2*DW-1:0] exp;
    exp = {32'h8000_0000, 32'h7FFF_FFFF};
    bus.volume = 32'sd2048;
    drive(2'b11, 32'sh7FFF_FFFF, 32'sh8000_0000);
    tick();                      // join: volume snapshot taken here
    bus.volume = 32'sd1;         // must not affect the frame in flight
    wait_valid(8, seen);
    vectors++;
    if (!seen || bus.out_data !== exp) begin
      miscompares++;
      $display("FAIL saturation: got seen=%0d data=%h required 1 %h", seen, bus.out_data, exp);
    end
  endtask

  task automatic test_overrun();
    bit seen;
    logic [2*DW-1:0] exp1, exp2;
    exp1 = {32'sd1, 32'sd7};
    exp2 = {32'sd5, 32'sd11};
    bus.volume = 32'sd1024;
    drive(2'b01, 32'sd7, 32'sd0);
    drive(2'b01, 32'sd9, 32'sd0);
    vectors++;
    if (bus.overrun !== 2'b01) begin
      miscompares++;
      $display("FAIL overrun_flag: got %b required 01", bus.overrun);
    end
    drive(2'b10, 32'sd0, 32'sd1);     // completes frame
    drive(2'b01, 32'sd11, 32'sd0);    // lands on the join edge
    vectors++;
    if (bus.overrun !== 2'b01) begin
      miscompares++;
      $display("FAIL join_edge_ovr: got %b required 01", bus.overrun);
    end
    wait_valid(8, seen);
    vectors++;
    if (!seen || bus.out_data !== exp1) begin
      miscompares++;
      $display("FAIL overrun_frame: got seen=%0d data=%h required 1 %h", seen, bus.out_data, exp1);
    end
    drive(2'b10, 32'sd0, 32'sd5);
    wait_valid(8, seen);
    vectors++;
    if (!seen || bus.out_data !== exp2 || bus.overrun !== 2'b01) begin
      miscompares++;
      $display("FAIL dbl_buffer: got seen=%0d data=%h ovr=%b required 1 %h 01",
               seen, bus.out_data, bus.overrun, exp2);
    end
  endtask

  task automatic test_back_to_back();
    int p1, p2, n;
    logic [2*DW-1:0] d1, d2;
    p1 = -1; p2 = -1; n = 0; d1 = '0; d2 = '0;
    bus.volume = 32'sd1024;
    drive(2'b11, 32'sd1, 32'sd2);     // E0
    tick();                           // E1 join
    drive(2'b11, 32'sd3, 32'sd4);     // E2: next frame pending during MULT
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.out_valid) begin
        n++;
        if (n == 1) begin p1 = k; d1 = bus.out_data; end
        else begin p2 = k; d2 = bus.out_data; end
      end
    end
    vectors++;
    if (n != 2 || p1 != 1 || p2 != 4) begin
      miscompares++;
      $display("FAIL b2b_timing: got %0d pulses at %0d,%0d required 2 at 1,4", n, p1, p2);
    end
    vectors++;
    if (d1 !== {32'sd2, 32'sd1} || d2 !== {32'sd4, 32'sd3}) begin
      miscompares++;
      $display("FAIL b2b_data: got %h,%h required %h,%h", d1, d2,
               {32'sd2, 32'sd1}, {32'sd4, 32'sd3});
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int stray;
    logic [2*DW-1:0] exp;
    exp = {32'sd200, 32'sd100};
    stray = 0;
    bus.volume = 32'sd1024;
    drive(2'b11, 32'sd5, 32'sd6);     // E0
    tick();                           // E1 join
    tick();                           // E2 first multiply
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.out_valid, bus.busy, bus.overrun, bus.out_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b busy=%b ovr=%b data=%h required all 0",
               bus.out_valid, bus.busy, bus.overrun, bus.out_data);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL aborted_frame: got %0d out_valid pulses required 0", stray);
    end
    drive(2'b11, 32'sd100, 32'sd200);
    wait_valid(8, seen);
    vectors++;
    if (!seen || bus.out_data !== exp) begin
      miscompares++;
      $display("FAIL post_reset: got seen=%0d data=%h required 1 %h", seen, bus.out_data, exp);
    end
  endtask

  initial begin
    clock        = 1'b0;
    reset        = 1'b1;
    vectors      = 0;
    miscompares  = 0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.volume   = '0;
    test_reset();
    test_basic();
    test_staggered();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
